gate_op_arbiter: RTL and testbench

- Shares one WIDTH-bit bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT) between two requesters.
- Each requester issues an opcode and operands through a valid/ready handshake. The block grants requesters round-robin, sequences the operation through a 3-state FSM and returns a registered result to the granted requester only.
- Sits between the lab's gate primitives and any control logic that needs gate results on demand.

---
 rtl/gate_op_arbiter.sv | 132 +++++++++++++
 tb/tb_gate_op_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Two-requester round-robin front end for a shared WIDTH-bit bitwise gate unit.
// One op in flight at a time; results come back as a one-cycle pulse to the granted requester.
//
// state | meaning
// IDLE  | arbitrate; accept one request from the granted requester
// EXEC  | evaluate the latched op and register the result for the granted requester
// RESP  | rsp*_valid pulse for the granted requester; update last_grant
module gate_op_arbiter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             grant;
    logic             gnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_d;
    logic             err_d;

    // Contention goes to whoever was not served last; otherwise the lone requester wins.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;
    assign busy       = (state_q != IDLE);

    always_comb begin
        result_d = '0;
        err_d    = 1'b0;
        case (op_q)
            3'd0:    result_d = a_q & b_q;
            3'd1:    result_d = a_q | b_q;
            3'd2:    result_d = ~(a_q & b_q);
            3'd3:    result_d = ~(a_q | b_q);
            3'd4:    result_d = a_q ^ b_q;
            3'd5:    result_d = ~(a_q ^ b_q);
            3'd6:    result_d = ~a_q;
            default: err_d    = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0_ready || req1_ready) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // The rsp registers double as the result register: they are loaded leaving EXEC,
    // so the data is stable during the RESP pulse and held until that requester's next op.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_data    <= '0;
            rsp0_err     <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_data    <= '0;
            rsp1_err     <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_ready) begin
                        gnt_q <= 1'b0;
                        op_q  <= req0_op;
                        a_q   <= req0_a;
                        b_q   <= req0_b;
                    end else if (req1_ready) begin
                        gnt_q <= 1'b1;
                        op_q  <= req1_op;
                        a_q   <= req1_a;
                        b_q   <= req1_b;
                    end
                end
                EXEC: begin
                    if (gnt_q) begin
                        rsp1_valid <= 1'b1;
                        rsp1_data  <= result_d;
                        rsp1_err   <= err_d;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_data  <= result_d;
                        rsp0_err   <= err_d;
                    end
                end
                RESP:    last_grant_q <= gnt_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Bench for gate_op_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference built from truth tables.
module tb_gate_op_arbiter;
    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
    logic [WIDTH-1:0] rsp0_data, rsp1_data;

    gate_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: phase counts cycles into the current op (0 = free to accept).
    int               m_phase;
    logic             m_last, m_g, m_err;
    logic [WIDTH-1:0] m_res;
    logic             m_rv [2];
    logic [WIDTH-1:0] m_rd [2];
    logic             m_re [2];
    logic             got0, got1;

    function automatic logic [3:0] truth(input logic [2:0] op);
        // bit index is {a,b}
        case (op)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            3'd6:    return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [3:0]       t;
        logic [WIDTH-1:0] r;
        t = truth(op);
        for (int i = 0; i < WIDTH; i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_last  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0;
            m_rd[i] = '0;
            m_re[i] = 1'b0;
        end
    endtask

    // One clock: check ready with current inputs, advance the model across the edge,
    // then check the registered outputs just after it.
    task automatic step();
        logic e0, e1;
        #1;
        e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
        e1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
        got0 = req0_ready;
        got1 = req1_ready;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_rv[0] = 1'b0;
            m_rv[1] = 1'b0;
            if (m_phase == 0) begin
                if (e0 || e1) begin
                    m_g   = e1;
                    m_err = e1 ? (req1_op == 3'd7) : (req0_op == 3'd7);
                    m_res = e1 ? ref_gate(req1_op, req1_a, req1_b)
                               : ref_gate(req0_op, req0_a, req0_b);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase     = 2;
                m_rv[m_g]   = 1'b1;
                m_rd[m_g]   = m_res;
                m_re[m_g]   = m_err;
            end else begin
                m_phase = 0;
                m_last  = m_g;
            end
        end
        #1;
        chk("rsp0_valid", rsp0_valid, m_rv[0]);
        chk("rsp0_data",  rsp0_data,  m_rd[0]);
        chk("rsp0_err",   rsp0_err,   m_re[0]);
        chk("rsp1_valid", rsp1_valid, m_rv[1]);
        chk("rsp1_data",  rsp1_data,  m_rd[1]);
        chk("rsp1_err",   rsp1_err,   m_re[1]);
        chk("busy",       busy,       m_phase != 0);
    endtask

    task automatic set_req(input int id, input logic v, input logic [2:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Holds valid until the handshake, then drops it (inputs scrambled afterwards).
    task automatic issue(input int id, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int  n;
        logic hit;
        n = 0;
        hit = 1'b0;
        set_req(id, 1'b1, op, a, b);
        while (!hit && n < 8) begin
            step();
            hit = (id == 0) ? got0 : got1;
            n++;
        end
        chk("handshake_seen", hit, 1'b1);
        set_req(id, 1'b0, 3'($urandom), WIDTH'($urandom), WIDTH'($urandom));
    endtask

    task automatic expect_rsp(input int id, input logic [WIDTH-1:0] d, input logic e);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 6) begin
            step();
            n++;
            seen = (id == 0) ? rsp0_valid : rsp1_valid;
        end
        chk("rsp_latency", n, 1);
        chk("rsp_data_const", (id == 0) ? rsp0_data : rsp1_data, d);
        chk("rsp_err_const",  (id == 0) ? rsp0_err  : rsp1_err,  e);
    endtask

    logic [WIDTH-1:0] sweep_exp [7];
    int               order [$];

    initial begin
        sweep_exp = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
        rst = 1'b1;
        set_req(0, 1'b0, 3'd0, '0, '0);
        set_req(1, 1'b0, 3'd0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_busy", busy, 1'b0);
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        chk("reset_rsp1_data", rsp1_data, 2'b00);
        rst = 1'b0;

        // basic AND on req0
        issue(0, 3'd0, 2'b11, 2'b01);
        expect_rsp(0, 2'b01, 1'b0);
        step();

        // opcode sweep on req1
        for (int k = 0; k < 7; k++) begin
            issue(1, 3'(k), 2'b10, 2'b11);
            expect_rsp(1, sweep_exp[k], 1'b0);
            step();
        end

        // fairness after reset: both held valid for 4 ops
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 3'd4, 2'b01, 2'b11);
        set_req(1, 1'b1, 3'd1, 2'b10, 2'b00);
        order.delete();
        for (int c = 0; c < 12; c++) begin
            step();
            if (got0) order.push_back(0);
            if (got1) order.push_back(1);
        end
        set_req(0, 1'b0, 3'd0, '0, '0);
        set_req(1, 1'b0, 3'd0, '0, '0);
        chk("grant_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk("grant_order", order[i], i % 2);
        repeat (2) step();

        // illegal opcode, then a legal op clears err
        issue(0, 3'd7, 2'b11, 2'b11);
        expect_rsp(0, 2'b00, 1'b1);
        step();
        issue(0, 3'd1, 2'b01, 2'b00);
        expect_rsp(0, 2'b01, 1'b0);
        step();

        // reset during EXEC of a req1 op
        issue(1, 3'd0, 2'b11, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_exec_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_exec_rsp1_data", rsp1_data, 2'b00);
        set_req(0, 1'b1, 3'd0, 2'b11, 2'b10);
        set_req(1, 1'b1, 3'd1, 2'b00, 2'b01);
        step();
        chk("post_rst_req0_first", got0, 1'b1);
        set_req(0, 1'b0, 3'd0, '0, '0);
        set_req(1, 1'b0, 3'd0, '0, '0);
        repeat (3) step();

        // req1 arrives while req0 is in flight
        issue(0, 3'd5, 2'b10, 2'b01);
        issue(1, 3'd3, 2'b00, 2'b10);
        expect_rsp(1, 2'b01, 1'b0);
        step();

        // random traffic with occasional resets and withdrawals
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_req(0, $urandom_range(0, 2) != 0, 3'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            set_req(1, $urandom_range(0, 2) != 0, 3'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end
endmodule
